// File: rtl/ad1_sample_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : ad1_sample_scheduler
//  Description : Sequencer and arbiter behind the dual-channel PmodAD1 SPI
//                capture engine. Detects new frames on the rising edge of
//                din_valid, block-averages 2^AVG_LOG2 frames per channel and
//                offers each averaged pair to two consumers through a
//                round-robin request/grant read port.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    AVG_LOG2   log2 of frames per average (0..4)
//  Ports
//    r_sclk     in   1   block clock, rising edge
//    reset      in   1   asynchronous reset, active low
//    enable     in   1   run control; 0 parks the sequencer in IDLE
//    din_valid  in   1   frame-valid level; rising edge = new frame
//    din0/din1  in  16   channel frames, code in [11:0]
//    req        in   2   per-consumer read request (level)
//    gnt        out  2   one-hot grant pulse
//    rd_valid   out  1   high with any grant
//    rd_data0/1 out 12   averaged values, captured at grant
//    pending    out  2   per-consumer unread-result flags
//    busy       out  1   sequencer not in IDLE
//    overrun    out  2   per-consumer lost-result flags
//  Build option
//    SCHED_OVERRUN_EN  when defined, overrun tracking is built; otherwise
//                      overrun is tied to 2'b00.
// ============================================================================
module ad1_sample_scheduler #(
    parameter int AVG_LOG2 = 2
) (
    input  logic        r_sclk,
    input  logic        reset,
    input  logic        enable,
    input  logic        din_valid,
    input  logic [15:0] din0,
    input  logic [15:0] din1,
    input  logic [1:0]  req,
    output logic [1:0]  gnt,
    output logic        rd_valid,
    output logic [11:0] rd_data0,
    output logic [11:0] rd_data1,
    output logic [1:0]  pending,
    output logic        busy,
    output logic [1:0]  overrun
);

    localparam int c_acc_w = 12 + AVG_LOG2;
    localparam int c_cnt_w = AVG_LOG2 + 1;
    localparam logic [c_cnt_w-1:0] c_window = c_cnt_w'(1) << AVG_LOG2;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ACC     = 2'd1,
        S_PUBLISH = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic                 r_dv_q;
    logic                 w_frame;
    logic [c_acc_w-1:0]   r_acc0;
    logic [c_acc_w-1:0]   r_acc1;
    logic [c_acc_w-1:0]   w_acc0_nxt;
    logic [c_acc_w-1:0]   w_acc1_nxt;
    logic [c_cnt_w-1:0]   r_cnt;
    logic [c_cnt_w-1:0]   w_cnt_nxt;
    logic [c_cnt_w-1:0]   w_cnt_inc;
    logic                 w_publish;
    logic [11:0]          r_res0;
    logic [11:0]          r_res1;
    logic [11:0]          w_avg0;
    logic [11:0]          w_avg1;
    logic [1:0]           r_pending;
    logic                 r_rr;
    logic [1:0]           w_elig;
    logic [1:0]           w_gnt;
    logic                 w_unused_bits;

    // Status nibbles of the capture frames carry nothing we need.
    assign w_unused_bits = &{1'b0, din0[15:12], din1[15:12]};

    assign w_frame   = din_valid & ~r_dv_q;
    assign w_cnt_inc = r_cnt + c_cnt_w'(1);
    assign w_avg0    = 12'(r_acc0 >> AVG_LOG2);
    assign w_avg1    = 12'(r_acc1 >> AVG_LOG2);

    // ------------------------------------------------------------------
    // Sequencer
    // ------------------------------------------------------------------
    always_ff @(posedge r_sclk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_dv_q  <= 1'b0;
            r_acc0  <= '0;
            r_acc1  <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_dv_q  <= din_valid;
            r_acc0  <= w_acc0_nxt;
            r_acc1  <= w_acc1_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_acc0_nxt  = r_acc0;
        w_acc1_nxt  = r_acc1;
        w_cnt_nxt   = r_cnt;
        w_publish   = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_acc0_nxt = '0;
                w_acc1_nxt = '0;
                w_cnt_nxt  = '0;
                if (enable) begin
                    w_state_nxt = S_ACC;
                end
            end
            S_ACC: begin
                if (!enable) begin
                    // Partial window is discarded.
                    w_state_nxt = S_IDLE;
                    w_acc0_nxt  = '0;
                    w_acc1_nxt  = '0;
                    w_cnt_nxt   = '0;
                end else if (w_frame) begin
                    w_acc0_nxt = r_acc0 + c_acc_w'(din0[11:0]);
                    w_acc1_nxt = r_acc1 + c_acc_w'(din1[11:0]);
                    w_cnt_nxt  = w_cnt_inc;
                    if (w_cnt_inc >= c_window) begin
                        w_state_nxt = S_PUBLISH;
                    end
                end
            end
            S_PUBLISH: begin
                w_publish = 1'b1;
                // A frame landing in the publish cycle starts the next window.
                if (w_frame) begin
                    w_acc0_nxt = c_acc_w'(din0[11:0]);
                    w_acc1_nxt = c_acc_w'(din1[11:0]);
                    w_cnt_nxt  = c_cnt_w'(1);
                end else begin
                    w_acc0_nxt = '0;
                    w_acc1_nxt = '0;
                    w_cnt_nxt  = '0;
                end
                w_state_nxt = enable ? S_ACC : S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign busy = (r_state != S_IDLE);

    // ------------------------------------------------------------------
    // Round-robin arbiter; r_rr names the consumer favoured on a tie.
    // ------------------------------------------------------------------
    assign w_elig = req & r_pending;

    always_comb begin
        w_gnt = 2'b00;
        case (w_elig)
            2'b01:   w_gnt = 2'b01;
            2'b10:   w_gnt = 2'b10;
            2'b11:   w_gnt = r_rr ? 2'b10 : 2'b01;
            default: w_gnt = 2'b00;
        endcase
    end

    always_ff @(posedge r_sclk or negedge reset) begin
        if (!reset) begin
            r_res0    <= '0;
            r_res1    <= '0;
            r_pending <= 2'b00;
            r_rr      <= 1'b0;
            gnt       <= 2'b00;
            rd_valid  <= 1'b0;
            rd_data0  <= '0;
            rd_data1  <= '0;
        end else begin
            if (w_publish) begin
                r_res0 <= w_avg0;
                r_res1 <= w_avg1;
            end
            // Publish set dominates the grant clear.
            r_pending <= (r_pending & ~w_gnt) | {2{w_publish}};
            if (w_gnt[0]) begin
                r_rr <= 1'b1;
            end else if (w_gnt[1]) begin
                r_rr <= 1'b0;
            end
            gnt      <= w_gnt;
            rd_valid <= |w_gnt;
            // r_res still holds the pre-publish value here.
            if (|w_gnt) begin
                rd_data0 <= r_res0;
                rd_data1 <= r_res1;
            end
        end
    end

    assign pending = r_pending;

    // ------------------------------------------------------------------
    // Lost-result tracking
    // ------------------------------------------------------------------
`ifdef SCHED_OVERRUN_EN
    logic [1:0] r_overrun;

    always_ff @(posedge r_sclk or negedge reset) begin
        if (!reset) begin
            r_overrun <= 2'b00;
        end else begin
            r_overrun <= (r_overrun & ~w_gnt) | (w_publish ? r_pending : 2'b00);
        end
    end

    assign overrun = r_overrun;
`else
    assign overrun = 2'b00;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ad1_sample_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ad1_sample_scheduler
//  Description : Self-checking bench for ad1_sample_scheduler (AVG_LOG2=2).
//                Directed scenarios followed by randomized traffic, compared
//                against a transaction-level reference model.
//                Honours SCHED_OVERRUN_EN for the overrun expectation.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ad1_sample_scheduler;

    localparam int c_frames = 4;

    logic        r_sclk = 1'b0;
    logic        reset = 1'b0;
    logic        enable = 1'b0;
    logic        din_valid = 1'b0;
    logic [15:0] din0 = '0;
    logic [15:0] din1 = '0;
    logic [1:0]  req = 2'b00;
    logic [1:0]  gnt;
    logic        rd_valid;
    logic [11:0] rd_data0;
    logic [11:0] rd_data1;
    logic [1:0]  pending;
    logic        busy;
    logic [1:0]  overrun;

    int checks = 0;
    int errors = 0;

    ad1_sample_scheduler #(.AVG_LOG2(2)) dut (
        .r_sclk    (r_sclk),
        .reset     (reset),
        .enable    (enable),
        .din_valid (din_valid),
        .din0      (din0),
        .din1      (din1),
        .req       (req),
        .gnt       (gnt),
        .rd_valid  (rd_valid),
        .rd_data0  (rd_data0),
        .rd_data1  (rd_data1),
        .pending   (pending),
        .busy      (busy),
        .overrun   (overrun)
    );

    always #5 r_sclk = ~r_sclk;

    // Reference model state
    int          m_cnt;
    int          m_sum0, m_sum1;
    bit          m_active, m_pub_due, m_dv, m_rr;
    logic [11:0] m_res0, m_res1, m_avg0, m_avg1, m_rd0, m_rd1;
    logic [1:0]  m_pend, m_ovr;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] ovr_exp(input logic [1:0] v);
`ifdef SCHED_OVERRUN_EN
        return v;
`else
        return 2'b00;
`endif
    endfunction

    task automatic model_reset();
        m_cnt = 0; m_sum0 = 0; m_sum1 = 0;
        m_active = 0; m_pub_due = 0; m_dv = 0; m_rr = 0;
        m_res0 = '0; m_res1 = '0; m_avg0 = '0; m_avg1 = '0;
        m_rd0 = '0; m_rd1 = '0; m_pend = 2'b00; m_ovr = 2'b00;
    endtask

    // One clock: predict from current inputs, advance, then compare.
    task automatic step();
        logic [1:0]  elig, g, old;
        bit          pub, frame, en;
        logic [11:0] c0, c1;
        elig  = req & m_pend;
        g     = (elig == 2'b11) ? (m_rr ? 2'b10 : 2'b01) : elig;
        pub   = m_pub_due;
        frame = din_valid && !m_dv;
        en    = enable;
        c0    = din0[11:0];
        c1    = din1[11:0];
        old   = m_pend;
        @(posedge r_sclk);
        if (g != 2'b00) begin
            m_rd0 = m_res0;
            m_rd1 = m_res1;
            m_rr  = g[0];
        end
        m_pend = (old & ~g) | (pub ? 2'b11 : 2'b00);
        m_ovr  = (m_ovr & ~g) | (pub ? old : 2'b00);
        if (pub) begin
            m_res0 = m_avg0;
            m_res1 = m_avg1;
        end
        m_pub_due = 0;
        if (pub) begin
            if (frame && en) begin
                m_sum0 = c0; m_sum1 = c1; m_cnt = 1;
            end else begin
                m_sum0 = 0; m_sum1 = 0; m_cnt = 0;
            end
            m_active = en;
        end else if (m_active) begin
            if (!en) begin
                m_active = 0; m_sum0 = 0; m_sum1 = 0; m_cnt = 0;
            end else if (frame) begin
                m_sum0 += c0; m_sum1 += c1; m_cnt++;
                if (m_cnt == c_frames) begin
                    m_avg0 = 12'(m_sum0 / c_frames);
                    m_avg1 = 12'(m_sum1 / c_frames);
                    m_pub_due = 1;
                    m_active  = 0;
                    m_sum0 = 0; m_sum1 = 0; m_cnt = 0;
                end
            end
        end else begin
            m_active = en;
            m_sum0 = 0; m_sum1 = 0; m_cnt = 0;
        end
        m_dv = din_valid;
        @(negedge r_sclk);
        chk("gnt", gnt, g);
        chk("rd_valid", rd_valid, |g);
        chk("rd_data0", rd_data0, m_rd0);
        chk("rd_data1", rd_data1, m_rd1);
        chk("pending", pending, m_pend);
        chk("busy", busy, m_active | m_pub_due);
        chk("overrun", overrun, ovr_exp(m_ovr));
    endtask

    task automatic frame(input logic [15:0] d0, input logic [15:0] d1);
        din0 = d0; din1 = d1; din_valid = 1'b1;
        step();
        din_valid = 1'b0;
        step();
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_gnt"}, gnt, 2'b00);
        chk({tag, "_rd_valid"}, rd_valid, 1'b0);
        chk({tag, "_rd_data0"}, rd_data0, 12'h000);
        chk({tag, "_rd_data1"}, rd_data1, 12'h000);
        chk({tag, "_pending"}, pending, 2'b00);
        chk({tag, "_busy"}, busy, 1'b0);
        chk({tag, "_overrun"}, overrun, 2'b00);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired before end of test");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        #1;
        check_reset_values("reset");
        @(negedge r_sclk);
        reset = 1'b1;

        // Averaging
        enable = 1'b1;
        step();
        frame(16'h0100, 16'hF0FF);
        frame(16'h0102, 16'hF0FF);
        frame(16'h0104, 16'hF0FF);
        frame(16'h0106, 16'hF0FF);
        chk("avg_pending", pending, 2'b11);

        // Read by consumer 0
        req = 2'b01;
        step();
        chk("read_gnt", gnt, 2'b01);
        chk("read_rd0", rd_data0, 12'h103);
        chk("read_rd1", rd_data1, 12'h0FF);
        step();
        step();
        chk("no_regrant", gnt, 2'b00);
        chk("pend_after_read", pending, 2'b10);
        req = 2'b10;
        step();
        req = 2'b00;
        step();

        // Round robin on two successive results
        for (int r = 0; r < 2; r++) begin
            for (int f = 0; f < c_frames; f++) frame(16'($urandom), 16'($urandom));
            req = 2'b11;
            step();
            chk("rr_first", gnt, 2'b01);
            step();
            chk("rr_second", gnt, 2'b10);
            req = 2'b00;
            step();
        end

        // Mid-window disable
        frame(16'h0FFF, 16'h0FFF);
        frame(16'h0FFF, 16'h0FFF);
        enable = 1'b0;
        step();
        chk("disable_busy", busy, 1'b0);
        enable = 1'b1;
        step();
        for (int f = 0; f < c_frames; f++) frame(16'h0200, 16'h0200);
        req = 2'b11;
        step();
        chk("clean_avg", rd_data0, 12'h200);
        step();
        req = 2'b00;
        step();

        // Overrun: two unread windows
        for (int f = 0; f < 2 * c_frames; f++) frame(16'($urandom), 16'($urandom));
        chk("ovr_both", overrun, ovr_exp(2'b11));
        req = 2'b01;
        step();
        chk("ovr_gnt", gnt, 2'b01);
        chk("ovr_after_read", overrun, ovr_exp(2'b10));
        req = 2'b10;
        step();
        req = 2'b00;
        step();

        // Reset mid-window
        for (int f = 0; f < 3; f++) frame(16'($urandom), 16'($urandom));
        reset = 1'b0;
        #1;
        check_reset_values("midreset");
        model_reset();
        @(negedge r_sclk);
        reset = 1'b1;
        step();
        for (int f = 0; f < 3; f++) frame(16'($urandom), 16'($urandom));
        chk("post_reset_3", pending, 2'b00);
        frame(16'($urandom), 16'($urandom));
        chk("post_reset_4", pending, 2'b11);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 2) == 0) din_valid = ~din_valid;
            din0   = 16'($urandom);
            din1   = 16'($urandom);
            req    = 2'($urandom);
            enable = ($urandom_range(0, 49) != 0);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
